// File: rtl/spi_slave_cnfg_mc_if.sv
// spi_slave_cnfg_mc_if: SPI pin, status-channel and register-file bundle; slave = config block, master = pads/FSM side
interface spi_slave_cnfg_mc_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 24,
  parameter int NCH = 4
);
  logic sc;
  logic mosi;
  logic miso;
  logic miso_oe_n;
  logic rram_busy;
  logic [NCH*DATA_W-1:0] ch_data;
  logic [DEPTH*DATA_W-1:0] cnfg_regs;
  logic wr_pulse;
  logic fsm_go;
  logic err;
  modport slave (
    input sc, mosi, rram_busy, ch_data,
    output miso, miso_oe_n, cnfg_regs, wr_pulse, fsm_go, err
  );
  modport master (
    output sc, mosi, rram_busy, ch_data,
    input miso, miso_oe_n, cnfg_regs, wr_pulse, fsm_go, err
  );
endinterface

// File: rtl/spi_slave_cnfg_mc.sv
// spi_slave_cnfg_mc: SPI slave decoding op/addr/data frames into a config register file, channel read-back and FSM trigger
// Ports: sclk (sole clock), rst (sync active-high), bus (slave modport: sc, mosi, miso, miso_oe_n, rram_busy,
//   ch_data, cnfg_regs, wr_pulse, fsm_go, err). Define SPI_SLAVE_CNFG_PARITY_EN to add even-parity bits to frames.
module spi_slave_cnfg_mc #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int DEPTH = 24,
  parameter int NCH = 4,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input logic sclk,
  input logic rst,
  spi_slave_cnfg_mc_if.slave bus
);
  localparam int MX = (ADDR_W > DATA_W) ? ADDR_W : (DATA_W > 2 ? DATA_W : 2);
  localparam int CW = $clog2(MX + 1);
`ifdef SPI_SLAVE_CNFG_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int WW = DATA_W - 1 + PAR;
  typedef enum logic [2:0] {OP, ADDR, WDATA, RDATA, DONE} state_t;
  state_t st, st_nx;
  logic [CW-1:0] cnt;
  logic [1:0] op;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic [WW-1:0] wd;
  logic [DATA_W-2:0] sh;
  logic [DEPTH*DATA_W-1:0] regs;
  logic [DATA_W-1:0] reg_rd, ch_rd, rd_word, wdata;
  logic miso, oe_n, wr_pulse, fsm_go, err;
  logic wr_in, par_ok, op_end, addr_end, wd_end, rd_end, wr_ok, wr_err, go_ok, go_err;
`ifdef SPI_SLAVE_CNFG_PARITY_EN
  logic rpar;
`endif
  assign addr_nx = {addr[ADDR_W-2:0], bus.mosi};
  assign rd_word = op[1] ? ch_rd : reg_rd;
  assign op_end = bus.sc && st == OP && cnt == CW'(1);
  assign addr_end = bus.sc && st == ADDR && cnt == CW'(ADDR_W - 1);
  assign wd_end = bus.sc && st == WDATA && cnt == CW'(DATA_W - 1 + PAR);
  assign rd_end = bus.sc && st == RDATA && cnt == CW'(DATA_W - 1 + PAR);
`ifdef SPI_SLAVE_CNFG_PARITY_EN
  // with parity the full word is already shifted in and mosi carries the parity bit
  assign wdata = wd;
  assign par_ok = ~^{op, addr, wd, bus.mosi};
`else
  assign wdata = {wd, bus.mosi};
  assign par_ok = 1'b1;
`endif
  // out-of-range writes are silently dropped; busy or bad parity flags err
  assign wr_ok = wd_end && wr_in && !bus.rram_busy && par_ok;
  assign wr_err = wd_end && (!par_ok || (wr_in && bus.rram_busy));
  assign go_ok = addr_end && op == 2'b11 && !bus.rram_busy;
  assign go_err = addr_end && op == 2'b11 && bus.rram_busy;
  // address decode uses the address including the bit being sampled on this edge
  always_comb begin
    reg_rd = '0;
    ch_rd = '0;
    wr_in = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      reg_rd = addr_nx == ADDR_W'(i) ? regs[i*DATA_W +: DATA_W] : reg_rd;
      wr_in = wr_in || addr == ADDR_W'(i);
    end
    for (int i = 0; i < NCH; i++)
      ch_rd = addr_nx == ADDR_W'(i) ? bus.ch_data[i*DATA_W +: DATA_W] : ch_rd;
  end
  always_comb begin
    st_nx = st;
    if (!bus.sc) st_nx = OP;
    else if (op_end) st_nx = ADDR;
    else if (addr_end) st_nx = op == 2'b01 ? WDATA : op == 2'b11 ? DONE : RDATA;
    else if (wd_end || rd_end) st_nx = DONE;
  end
  always_ff @(posedge sclk) st <= rst ? OP : st_nx;
  always_ff @(posedge sclk) begin
    if (rst) begin
      regs <= {DEPTH{RST_VAL}};
      cnt <= '0;
      op <= '0;
      addr <= '0;
      wd <= '0;
      sh <= '0;
      miso <= 1'b0;
      oe_n <= 1'b1;
      wr_pulse <= 1'b0;
      fsm_go <= 1'b0;
      err <= 1'b0;
`ifdef SPI_SLAVE_CNFG_PARITY_EN
      rpar <= 1'b0;
`endif
    end else begin
      wr_pulse <= wr_ok;
      fsm_go <= go_ok;
      err <= err || wr_err || go_err;
      for (int i = 0; i < DEPTH; i++)
        if (wr_ok && addr == ADDR_W'(i)) regs[i*DATA_W +: DATA_W] <= wdata;
      if (!bus.sc) begin
        cnt <= '0;
        miso <= 1'b0;
        oe_n <= 1'b1;
      end else begin
        cnt <= (op_end || addr_end || wd_end || rd_end) ? '0 : st == DONE ? cnt : cnt + 1'b1;
        if (st == OP) op <= {op[0], bus.mosi};
        if (st == ADDR) addr <= addr_nx;
        if (st == WDATA) wd <= {wd[WW-2:0], bus.mosi};
        if (addr_end && !op[0]) begin
          sh <= rd_word[DATA_W-2:0];
          miso <= rd_word[DATA_W-1];
          oe_n <= 1'b0;
`ifdef SPI_SLAVE_CNFG_PARITY_EN
          rpar <= ^rd_word;
`endif
        end else if (rd_end) begin
          miso <= 1'b0;
          oe_n <= 1'b1;
        end else if (st == RDATA) begin
`ifdef SPI_SLAVE_CNFG_PARITY_EN
          miso <= cnt == CW'(DATA_W - 1) ? rpar : sh[DATA_W-2];
`else
          miso <= sh[DATA_W-2];
`endif
          sh <= sh << 1;
        end
      end
    end
  end
  assign bus.cnfg_regs = regs;
  assign bus.miso = miso;
  assign bus.miso_oe_n = oe_n;
  assign bus.wr_pulse = wr_pulse;
  assign bus.fsm_go = fsm_go;
  assign bus.err = err;
endmodule

// File: tb/tb_spi_slave_cnfg_mc.sv
// tb_spi_slave_cnfg_mc: directed scoreboard bench for the SPI config slave (default build, no parity)
module tb_spi_slave_cnfg_mc;
  localparam int DW = 16;
  localparam int DEP = 24;
  localparam int NC = 4;
  logic sclk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int go_cnt = 0;
  logic [DW-1:0] mdl [DEP];
  logic [DW-1:0] chv [NC];
  logic [DW-1:0] exp_q [$];
  spi_slave_cnfg_mc_if #(.DATA_W(DW), .DEPTH(DEP), .NCH(NC)) bus ();
  spi_slave_cnfg_mc dut (.sclk(sclk), .rst(rst), .bus(bus));
  always #5 sclk = ~sclk;
  always @(negedge sclk) begin
    if (bus.wr_pulse === 1'b1) wr_cnt++;
    if (bus.fsm_go === 1'b1) go_cnt++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [DEP*DW-1:0] obs, input logic [DEP*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [DEP*DW-1:0] flat();
    logic [DEP*DW-1:0] r;
    for (int i = 0; i < DEP; i++) r[i*DW +: DW] = mdl[i];
    return r;
  endfunction
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sclk);
      @(negedge sclk);
    end
  endtask
  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.sc = 1'b1;
      bus.mosi = v[i];
      @(posedge sclk);
      @(negedge sclk);
    end
  endtask
  task automatic end_frame();
    bus.sc = 1'b0;
    bus.mosi = 1'b0;
    idle(1);
  endtask
  task automatic write(input logic [4:0] a, input logic [DW-1:0] d);
    send({2'b01, a, d}, 2 + 5 + DW);
    end_frame();
  endtask
  task automatic read(input logic ch, input logic [4:0] a);
    logic [DW-1:0] w;
    logic [DW-1:0] e;
    int low;
    bit was_low;
    bit done;
    w = '0;
    low = 0;
    was_low = 0;
    done = 0;
    if (ch) exp_q.push_back(int'(a) < NC ? chv[a[1:0]] : '0);
    else exp_q.push_back(int'(a) < DEP ? mdl[a] : '0);
    send({ch, 1'b0, a}, 7);
    for (int k = 0; k < 40 && !done; k++) begin
      if (bus.miso_oe_n === 1'b0) begin
        w = {w[DW-2:0], bus.miso};
        low++;
        was_low = 1;
      end else if (was_low) done = 1;
      if (!done) begin
        bus.mosi = 1'b0;
        @(posedge sclk);
        @(negedge sclk);
      end
    end
    e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
    check($sformatf("read_%s_a%0d_data", ch ? "ch" : "reg", a), w, e);
    check($sformatf("read_%s_a%0d_oe_cycles", ch ? "ch" : "reg", a), low, DW);
    check($sformatf("read_%s_a%0d_miso_idle", ch ? "ch" : "reg", a), bus.miso, 1'b0);
    end_frame();
  endtask
  initial begin
    int w0;
    int g0;
    rst = 1'b1;
    bus.sc = 1'b0;
    bus.mosi = 1'b0;
    bus.rram_busy = 1'b0;
    chv[0] = 16'h0001;
    chv[1] = 16'h5555;
    chv[2] = 16'h1234;
    chv[3] = 16'hFFFF;
    bus.ch_data = {chv[3], chv[2], chv[1], chv[0]};
    for (int i = 0; i < DEP; i++) mdl[i] = '0;
    repeat (3) @(negedge sclk);
    check("rst_miso", bus.miso, 1'b0);
    check("rst_oe_n", bus.miso_oe_n, 1'b1);
    check("rst_wr_pulse", bus.wr_pulse, 1'b0);
    check("rst_fsm_go", bus.fsm_go, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_regs", bus.cnfg_regs, flat());
    rst = 1'b0;
    idle(1);
    read(1'b0, 5'd3);
    check("err_after_read3", bus.err, 1'b0);
    write(5'd7, 16'hA5C3);
    mdl[7] = 16'hA5C3;
    idle(1);
    check("wr_pulse_count_a7", wr_cnt, 1);
    check("reg7_value", bus.cnfg_regs[7*DW +: DW], 16'hA5C3);
    read(1'b0, 5'd7);
    write(5'd30, 16'hBEEF);
    idle(1);
    check("wr_pulse_count_a30", wr_cnt, 1);
    check("regs_after_a30", bus.cnfg_regs, flat());
    read(1'b0, 5'd30);
    check("err_after_a30", bus.err, 1'b0);
    write(5'd23, 16'h8001);
    mdl[23] = 16'h8001;
    idle(1);
    check("wr_pulse_count_a23", wr_cnt, 2);
    read(1'b0, 5'd23);
    read(1'b1, 5'd2);
    read(1'b1, 5'd5);
    read(1'b1, 5'd3);
    g0 = go_cnt;
    send({2'b11, 5'd0}, 7);
    end_frame();
    idle(1);
    check("fsm_go_idle_count", go_cnt, g0 + 1);
    check("err_after_go_idle", bus.err, 1'b0);
    bus.rram_busy = 1'b1;
    send({2'b11, 5'd0}, 7);
    end_frame();
    bus.rram_busy = 1'b0;
    idle(1);
    check("fsm_go_busy_count", go_cnt, g0 + 1);
    check("err_after_go_busy", bus.err, 1'b1);
    w0 = wr_cnt;
    send({2'b01, 5'd1, 8'hAB}, 15);
    end_frame();
    idle(1);
    check("abort_reg1", bus.cnfg_regs[1*DW +: DW], 16'h0000);
    check("abort_wr_count", wr_cnt, w0);
    write(5'd1, 16'h00FF);
    mdl[1] = 16'h00FF;
    idle(1);
    check("full_wr_count", wr_cnt, w0 + 1);
    check("regs_after_a1", bus.cnfg_regs, flat());
    read(1'b0, 5'd1);
    check("err_sticky", bus.err, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave_cnfg_mc.md
Name: spi_slave_cnfg_mc

Overview:
Parametrised SPI slave front end for the RRAM configuration path. It decodes opcode/address/data frames into a DEPTH-entry configuration register file, reads back registers or NCH status channels, and issues a one-cycle FSM trigger. Its generalised width, depth and channel count allow one RTL to serve every test-chip variant. It sits between the pad-level SPI pins and the RRAM program FSM.

Parameters:
ADDR_W, 5, address field width in bits
DATA_W, 16, register and channel word width
DEPTH, 24, number of configuration registers; must satisfy DEPTH <= 2**ADDR_W
NCH, 4, number of read-back status channels; must satisfy NCH <= 2**ADDR_W
RST_VAL, 0, reset value of every configuration register

Ports:
sclk  in  1  SPI clock, sole clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
sc  in  1  chip select, active-high; low forces frame abort
mosi  in  1  serial data in, MSB first
miso  out  1  serial data out
miso_oe_n  out  1  miso output enable, active-low
rram_busy  in  1  program FSM active
ch_data  in  NCH*DATA_W  status channels, channel k in bits [k*DATA_W +: DATA_W]
cnfg_regs  out  DEPTH*DATA_W  register file contents, flattened the same way
wr_pulse  out  1  one-cycle pulse after a committed write
fsm_go  out  1  one-cycle FSM trigger
err  out  1  sticky error flag

Behaviour:
- Reset (rst=1 at edge): all registers = RST_VAL; miso=0, miso_oe_n=1, wr_pulse=0, fsm_go=0, err=0; state=OP.
- Frame format: opcode[1:0] (2 bits), then ADDR_W address bits, then data phase; all fields MSB first. Opcodes: 00 = read register, 01 = write register, 10 = read channel, 11 = fsm_go.
- States: OP -> ADDR -> {WDATA | RDATA | DONE} -> DONE. A bit counter sized for max(2, ADDR_W, DATA_W) counts within each phase.
- OP: 2 sampled bits, then -> ADDR.
- ADDR, at the edge sampling the last address bit:
  - Opcode 00/10: latch the selected word into the shift register, drive miso = MSB and miso_oe_n = 0 from that edge, -> RDATA.
  - Opcode 01: -> WDATA.
  - Opcode 11: -> DONE. If rram_busy=0, fsm_go=1 for the next cycle; otherwise no pulse and err<=1.
- RDATA: each edge shifts the next bit onto miso for DATA_W bits total. The edge after the LSB is presented sets miso_oe_n=1, miso=0, -> DONE.
- Read sources:
  - Opcode 00: register at addr if addr < DEPTH, else 0.
  - Opcode 10: ch_data channel addr if addr < NCH, else 0. Sampled at the latch edge only.
- WDATA, at the edge sampling the DATA_W-th bit:
  - If addr < DEPTH and rram_busy=0: reg[addr] updates that edge and wr_pulse=1 the next cycle.
  - If addr >= DEPTH: the write is dropped and err is unchanged.
  - If rram_busy=1: the write is dropped and err<=1.
  - Next state DONE in every case.
- DONE: ignores mosi until sc goes low.
- sc=0 at any edge: state -> OP, counters cleared, miso_oe_n=1, partial write discarded, registers unchanged. wr_pulse/fsm_go already scheduled still fire.
- rst has priority over sc.
- err clears only on rst.

Optional Feature:
SPI_SLAVE_CNFG_PARITY_EN
- With the macro: every write frame carries one extra even-parity bit after the data, covering opcode+addr+data. On mismatch the write is dropped and err<=1. Read frames append one even-parity bit (over the data word) after the LSB, so miso_oe_n stays low DATA_W+1 cycles.
- Without the macro: no parity bit in either direction, and frame lengths are exactly as above.

Test Plan:
- Reset, then read addr 3 -> miso returns 0x0000 over 16 cycles with miso_oe_n low exactly 16 cycles; err=0.
- Write 0xA5C3 to addr 7, read back addr 7 -> cnfg_regs[7*16+:16]=0xA5C3, wr_pulse high exactly 1 cycle, readback 0xA5C3.
- Write addr 30 (>= DEPTH), then read addr 30 -> no register changes, read returns 0, err=0.
- ch_data channel 2 = 0x1234, read-channel addr 2 then addr 5 -> 0x1234, then 0x0000.
- fsm_go frame with rram_busy=0, then again with rram_busy=1 -> one fsm_go pulse only, err=1 after the second frame.
- Drop sc after 8 of 16 write-data bits to addr 1, then do a full write of 0x00FF to addr 1 -> first write discarded, reg[1]=0x00FF, one wr_pulse total.
